layer_pipe_ctrl_pl: RTL

Parametrised pipeline sequencer for an nlayers-deep chain of pipelined layer blocks.
- Replaces the per-layer comp/sumchk enable shift chain with one central controller.
- Drives the global en pulse and the per-layer comp_en/sumchk_en vectors, collects per-layer ready pulses and assigns instance ids.
- Supports fixed-count and continuous modes, graceful stop/drain and a watchdog.

---
 rtl/layer_pipe_ctrl_pl_if.sv | 29 ++
 rtl/layer_pipe_ctrl_pl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/layer_pipe_ctrl_pl_if.sv
// Handshake bundle between the layer pipeline controller and the layer chain.
interface layer_pipe_ctrl_pl_if #(
    parameter int unsigned nlayers = 4,
    parameter int unsigned idw     = 32
);
    logic               start;
    logic [idw-1:0]     ninst;
    logic               stop;
    logic [nlayers-1:0] comp_ready_pulse;
    logic [nlayers-1:0] sumchk_ready_pulse;
    logic               en;
    logic [nlayers-1:0] comp_en;
    logic [nlayers-1:0] sumchk_en;
    logic [idw-1:0]     id_c;
    logic [idw-1:0]     step_cnt;
    logic               busy;
    logic               done_pulse;
    logic               err;

    modport master (
        input  start, ninst, stop, comp_ready_pulse, sumchk_ready_pulse,
        output en, comp_en, sumchk_en, id_c, step_cnt, busy, done_pulse, err
    );

    modport slave (
        output start, ninst, stop, comp_ready_pulse, sumchk_ready_pulse,
        input  en, comp_en, sumchk_en, id_c, step_cnt, busy, done_pulse, err
    );
endinterface

// File: rtl/layer_pipe_ctrl_pl.sv
// Central step sequencer for an nlayers-deep comp/sumcheck layer pipeline:
// issues en pulses, shifts stage enables, gathers ready pulses, watchdog.
module layer_pipe_ctrl_pl #(
    parameter int unsigned nlayers = 4,
    parameter int unsigned idw     = 32,
    parameter int unsigned timeout = 0
) (
    input logic                  clk,
    input logic                  rstb,
    layer_pipe_ctrl_pl_if.master bus
);
    localparam int unsigned WDW = 32;

    typedef enum logic [1:0] {IDLE, FIRE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [nlayers-1:0] comp_en_q, comp_en_d, sumchk_en_q, sumchk_en_d;
    logic [nlayers-1:0] cdone_q, cdone_d, sdone_q, sdone_d;
    logic [idw-1:0]     remaining_q, remaining_d, id_q, id_d, next_id_q, next_id_d;
    logic [idw-1:0]     step_cnt_q, step_cnt_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               cont_q, cont_d, stop_q, stop_d, err_q, err_d;
    logic               en_q, en_d, busy_q, busy_d, done_q, done_d;

    logic [nlayers-1:0] comp_sh, sum_sh, cdone_n, sdone_n;
    logic [idw-1:0]     rem_b, nid_b;
    logic               cont_b, stop_b, inj, complete, do_shift;

    // Next-state, shift and step bookkeeping
    always_comb begin
        state_d     = state_q;
        comp_en_d   = comp_en_q;
        sumchk_en_d = sumchk_en_q;
        cdone_d     = cdone_q;
        sdone_d     = sdone_q;
        remaining_d = remaining_q;
        cont_d      = cont_q;
        id_d        = id_q;
        next_id_d   = next_id_q;
        step_cnt_d  = step_cnt_q;
        stop_d      = stop_q;
        err_d       = err_q;
        wd_d        = wd_q;
        do_shift    = 1'b0;

        rem_b  = remaining_q;
        cont_b = cont_q;
        nid_b  = next_id_q;
        stop_b = stop_q | bus.stop;
        if (state_q == IDLE) begin
            rem_b  = bus.ninst;
            cont_b = (bus.ninst == '0);
            nid_b  = '0;
            stop_b = bus.stop;
        end
        inj = (rem_b != '0 || cont_b) && !stop_b;

        comp_sh[0] = inj;
        for (int k = 1; k < int'(nlayers); k++) comp_sh[k] = comp_en_q[k-1];
        sum_sh[nlayers-1] = comp_en_q[nlayers-1];
        for (int k = 0; k < int'(nlayers) - 1; k++) sum_sh[k] = sumchk_en_q[k+1];

        // Pulses arriving this cycle count toward completion
        cdone_n  = cdone_q | (bus.comp_ready_pulse & comp_en_q);
        sdone_n  = sdone_q | (bus.sumchk_ready_pulse & sumchk_en_q);
        complete = &((~comp_en_q | cdone_n) & (~sumchk_en_q | sdone_n));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d      = 1'b0;
                    stop_d     = bus.stop;
                    step_cnt_d = '0;
                    do_shift   = 1'b1;
                end
            end
            FIRE: begin
                step_cnt_d = step_cnt_q + idw'(1);
                cdone_d    = '0;
                sdone_d    = '0;
                wd_d       = '0;
                stop_d     = stop_b;
                state_d    = WAIT;
            end
            WAIT: begin
                stop_d  = stop_b;
                cdone_d = cdone_n;
                sdone_d = sdone_n;
                wd_d    = wd_q + WDW'(1);
                if ((|(bus.comp_ready_pulse & ~comp_en_q)) ||
                    (|(bus.sumchk_ready_pulse & ~sumchk_en_q)))
                    err_d = 1'b1;
                if (complete) begin
                    do_shift = 1'b1;
                end else if (timeout != 0 && wd_d >= WDW'(timeout)) begin
                    err_d       = 1'b1;
                    comp_en_d   = '0;
                    sumchk_en_d = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_shift) begin
            comp_en_d   = comp_sh;
            sumchk_en_d = sum_sh;
            remaining_d = rem_b;
            cont_d      = cont_b;
            next_id_d   = nid_b;
            if (inj) begin
                id_d      = nid_b;
                next_id_d = nid_b + idw'(1);
                if (!cont_b) remaining_d = rem_b - idw'(1);
            end
            state_d = ((|comp_sh) || (|sum_sh)) ? FIRE : DONE;
        end

        en_d   = (state_d == FIRE);
        busy_d = (state_d == FIRE) || (state_d == WAIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= IDLE;
            comp_en_q   <= '0;
            sumchk_en_q <= '0;
            cdone_q     <= '0;
            sdone_q     <= '0;
            remaining_q <= '0;
            cont_q      <= 1'b0;
            id_q        <= '0;
            next_id_q   <= '0;
            step_cnt_q  <= '0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            comp_en_q   <= comp_en_d;
            sumchk_en_q <= sumchk_en_d;
            cdone_q     <= cdone_d;
            sdone_q     <= sdone_d;
            remaining_q <= remaining_d;
            cont_q      <= cont_d;
            id_q        <= id_d;
            next_id_q   <= next_id_d;
            step_cnt_q  <= step_cnt_d;
            stop_q      <= stop_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.en         = en_q;
    assign bus.comp_en    = comp_en_q;
    assign bus.sumchk_en  = sumchk_en_q;
    assign bus.id_c       = comp_en_q[0] ? id_q : '0;
    assign bus.step_cnt   = step_cnt_q;
    assign bus.busy       = busy_q;
    assign bus.done_pulse = done_q;
    assign bus.err        = err_q;
endmodule
